m_uart_tx_arb: RTL and testbench

M_UART_TX_ARB -- requirements
Module: m_uart_tx_arb

---
 rtl/m_uart_tx_arb.sv | 113 +++++++++++
 tb/tb_m_uart_tx_arb.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/m_uart_tx_arb.sv
// Four-requester round-robin arbiter in front of a UART byte transmitter.
// Issues one byte per frame and holds off for a full frame after reset.
module m_uart_tx_arb #(
    parameter int UART_CNT = 100
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic [3:0]  w_req,
    input  logic [31:0] w_data,
    output logic [3:0]  w_ack,
    output logic        w_we,
    output logic [7:0]  w_dout,
    output logic        w_busy
);

    localparam int          FRAME      = 10 * UART_CNT;
    localparam logic [15:0] FRAME_LAST = 16'(FRAME - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic [1:0]  ptr_r;
    logic [1:0]  ptr_s;
    logic [1:0]  grant_s;
    logic        we_s;
    logic [3:0]  ack_s;
    logic [7:0]  dout_s;
    logic        busy_s;

    // First set request bit at or above ptr, wrapping modulo 4.
    function automatic logic [1:0] f_rr_grant(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        f_rr_grant = ptr;
        found      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                f_rr_grant = idx;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    // Next-state, counter, pointer and output decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ptr_s   = ptr_r;
        we_s    = 1'b0;
        ack_s   = 4'b0000;
        dout_s  = w_dout;
        grant_s = f_rr_grant(w_req, ptr_r);
        case (state_r)
            ST_IDLE: begin
                if (w_req != 4'b0000) begin
                    we_s    = 1'b1;
                    dout_s  = w_data[{grant_s, 3'b000} +: 8];
                    ack_s   = 4'b0001 << grant_s;
                    ptr_s   = grant_s + 2'd1;
                    cnt_s   = 16'd1;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Requests are deliberately ignored until the frame has been shifted out.
                cnt_s = cnt_r + 16'd1;
                if (cnt_r == FRAME_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_WAIT;
                cnt_s   = 16'd0;
            end
        endcase
        busy_s = (state_s == ST_WAIT);
    end

    // State register and registered outputs; reset enters the holdoff frame.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_r <= ST_WAIT;
            cnt_r   <= 16'd0;
            ptr_r   <= 2'd0;
            w_we    <= 1'b0;
            w_ack   <= 4'b0000;
            w_dout  <= 8'h00;
            w_busy  <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
            w_we    <= we_s;
            w_ack   <= ack_s;
            w_dout  <= dout_s;
            w_busy  <= busy_s;
        end
    end

endmodule

// File: tb/tb_m_uart_tx_arb.sv
// Directed testbench for m_uart_tx_arb with UART_CNT=100 (FRAME=1000).
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
`timescale 1ns/1ps
module tb_m_uart_tx_arb;

    logic        w_clk;
    logic        w_rst_n;
    logic [3:0]  w_req;
    logic [31:0] w_data;
    logic [3:0]  w_ack;
    logic        w_we;
    logic [7:0]  w_dout;
    logic        w_busy;

    int errors = 0;
    int checks = 0;

    m_uart_tx_arb #(.UART_CNT(100)) dut (
        .w_clk  (w_clk),
        .w_rst_n(w_rst_n),
        .w_req  (w_req),
        .w_data (w_data),
        .w_ack  (w_ack),
        .w_we   (w_we),
        .w_dout (w_dout),
        .w_busy (w_busy)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Advance until w_we is seen; n = edges consumed, ok = seen within limit.
    task automatic wait_we(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            tick();
            n++;
            if (w_we) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        w_req   = 4'b0000;
        w_data  = 32'h0;
        #23;
        checks++; if (w_we !== 1'b0)     begin errors++; $display("FAIL reset_we got=%b exp=0", w_we); end
        checks++; if (w_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got=%b exp=0000", w_ack); end
        checks++; if (w_dout !== 8'h00)  begin errors++; $display("FAIL reset_dout got=%h exp=00", w_dout); end
        checks++; if (w_busy !== 1'b1)   begin errors++; $display("FAIL reset_busy got=%b exp=1", w_busy); end
    endtask

    task automatic test_holdoff();
        bit early = 1'b0;
        logic busy_999 = 1'b0;
        tick();
        w_req   = 4'b0001;
        w_data  = 32'h44332211;
        w_rst_n = 1'b1;
        for (int e = 1; e <= 1000; e++) begin
            tick();
            if (w_we || (w_ack != 4'b0000)) early = 1'b1;
            if (e == 999) busy_999 = w_busy;
        end
        checks++; if (early !== 1'b0)  begin errors++; $display("FAIL holdoff_early got=%b exp=0", early); end
        checks++; if (busy_999 !== 1'b1) begin errors++; $display("FAIL holdoff_busy999 got=%b exp=1", busy_999); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL holdoff_busy1000 got=%b exp=0", w_busy); end
        tick();
        checks++; if (w_we !== 1'b1)     begin errors++; $display("FAIL holdoff_we1001 got=%b exp=1", w_we); end
        checks++; if (w_ack !== 4'b0001) begin errors++; $display("FAIL holdoff_ack got=%b exp=0001", w_ack); end
        checks++; if (w_dout !== 8'h11)  begin errors++; $display("FAIL holdoff_dout got=%h exp=11", w_dout); end
        w_req = 4'b0000;
        tick();
        checks++; if (w_we !== 1'b0 || w_ack !== 4'b0000) begin errors++; $display("FAIL holdoff_pulse we=%b ack=%b exp=0/0000", w_we, w_ack); end
    endtask

    task automatic test_single();
        int n = 0;
        int we_cnt = 0;
        logic busy_1 = 1'b0;
        logic busy_998 = 1'b0;
        while (w_busy && n < 1100) begin tick(); n++; end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", w_busy); end
        w_req  = 4'b0100;
        w_data = 32'hAA61BBCC;
        tick();
        checks++; if (w_we !== 1'b1)     begin errors++; $display("FAIL single_we got=%b exp=1", w_we); end
        checks++; if (w_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b exp=0100", w_ack); end
        checks++; if (w_dout !== 8'h61)  begin errors++; $display("FAIL single_dout got=%h exp=61", w_dout); end
        w_req = 4'b0000;
        for (int k = 1; k <= 999; k++) begin
            tick();
            if (w_we) we_cnt++;
            if (k == 1) busy_1 = w_busy;
            if (k == 998) busy_998 = w_busy;
        end
        checks++; if (busy_1 !== 1'b1)   begin errors++; $display("FAIL single_busy1 got=%b exp=1", busy_1); end
        checks++; if (busy_998 !== 1'b1) begin errors++; $display("FAIL single_busy998 got=%b exp=1", busy_998); end
        checks++; if (w_busy !== 1'b0)   begin errors++; $display("FAIL single_busy999 got=%b exp=0", w_busy); end
        checks++; if (we_cnt !== 0)      begin errors++; $display("FAIL single_extra_we got=%0d exp=0", we_cnt); end
        checks++; if (w_dout !== 8'h61)  begin errors++; $display("FAIL single_dout_hold got=%h exp=61", w_dout); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] exp_dout[5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};
        int n;
        bit ok;
        w_rst_n = 1'b0;
        #7;
        w_req   = 4'b1111;
        w_data  = 32'hD3C2B1A0;
        tick();
        w_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_we(1100, n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_timeout grant=%0d", k); end
            checks++; if (n !== ((k == 0) ? 1001 : 1000)) begin errors++; $display("FAIL rr_spacing grant=%0d got=%0d exp=%0d", k, n, (k == 0) ? 1001 : 1000); end
            checks++; if (w_ack !== exp_ack[k])  begin errors++; $display("FAIL rr_ack grant=%0d got=%b exp=%b", k, w_ack, exp_ack[k]); end
            checks++; if (w_dout !== exp_dout[k]) begin errors++; $display("FAIL rr_dout grant=%0d got=%h exp=%h", k, w_dout, exp_dout[k]); end
        end
        w_req = 4'b0000;
    endtask

    task automatic test_withdraw();
        int we_cnt = 0;
        int ack_cnt = 0;
        for (int k = 0; k < 3200; k++) begin
            if (k == 100) w_req = 4'b0010;
            if (k == 150) w_req = 4'b0000;
            tick();
            if (w_we) we_cnt++;
            if (w_ack != 4'b0000) ack_cnt++;
        end
        checks++; if (we_cnt !== 0)    begin errors++; $display("FAIL withdraw_we got=%0d exp=0", we_cnt); end
        checks++; if (ack_cnt !== 0)   begin errors++; $display("FAIL withdraw_ack got=%0d exp=0", ack_cnt); end
        checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL withdraw_busy got=%b exp=0", w_busy); end
    endtask

    task automatic test_midframe_reset();
        int n;
        bit ok;
        w_req  = 4'b0001;
        w_data = 32'h000000E7;
        tick();
        checks++; if (w_we !== 1'b1 || w_dout !== 8'hE7) begin errors++; $display("FAIL mid_grant we=%b dout=%h exp=1/e7", w_we, w_dout); end
        w_req = 4'b0000;
        for (int k = 0; k < 300; k++) tick();
        w_rst_n = 1'b0;
        #1;
        checks++; if (w_we !== 1'b0 || w_ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_pulse we=%b ack=%b exp=0/0000", w_we, w_ack); end
        checks++; if (w_busy !== 1'b1)  begin errors++; $display("FAIL mid_rst_busy got=%b exp=1", w_busy); end
        checks++; if (w_dout !== 8'h00) begin errors++; $display("FAIL mid_rst_dout got=%h exp=00", w_dout); end
        w_req = 4'b0001;
        tick();
        tick();
        w_rst_n = 1'b1;
        wait_we(1100, n, ok);
        checks++; if (!ok || n !== 1001) begin errors++; $display("FAIL mid_holdoff got=%0d exp=1001", n); end
        checks++; if (w_ack !== 4'b0001) begin errors++; $display("FAIL mid_ack got=%b exp=0001", w_ack); end
        w_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_holdoff();
        test_single();
        test_round_robin();
        test_withdraw();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
